agent_config_loader: RTL and testbench

Upstream configuration sequencer for the agent array. Accepts a stream of 32-bit configuration words over a valid/ready handshake and converts it into the per-agent `seedValue`/`loadSeed` and `initState`/`loadState` pulses, with the matching `address`, that the agents consume. It loads a recovery-PRBS seed and then an initial SUS/INF state into every agent in address order, then reports completion.

---
 rtl/agent_config_loader_pkg.sv | 46 ++++
 rtl/agent_config_loader_if.sv | 41 ++++
 rtl/agent_config_loader.sv | 144 ++++++++++++++
 tb/tb_agent_config_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/agent_config_loader_pkg.sv
// ============================================================================
//  Package     : agent_cfg_pkg
//  Description : Shared types and constants for the agent configuration
//                loader: FSM state encoding, word-order tags, seed zero
//                substitute and the SUS/INF state encodings used by agents.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package agent_cfg_pkg;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_STATE = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_e;

  // Each agent consumes two words: A (seed) first, then B (state)
  typedef enum logic {
    WORD_SEED  = 1'b0,
    WORD_STATE = 1'b1
  } cfg_word_e;

  localparam cfg_word_e WORD_A = WORD_SEED;
  localparam cfg_word_e WORD_B = WORD_STATE;

  // Only this bit of the state word carries information
  localparam int STATE_BIT = 0;

  // Agent initial-state encodings
  localparam logic AGENT_SUS = 1'b0;
  localparam logic AGENT_INF = 1'b1;

  // An all-zero PRBS seed locks the generator; this replaces it
  localparam logic [31:0] SEED_ZERO_SUB = 32'h0000_0001;

  // Returns the seed with the all-zero value replaced by the substitute
  function automatic logic [31:0] guard_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? SEED_ZERO_SUB : seed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/agent_config_loader_if.sv
// ============================================================================
//  Interface   : agent_config_loader_if
//  Description : Configuration word handshake plus the per-agent load
//                outputs of the loader. master = word source / agent side,
//                slave = the loader itself.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface agent_config_loader_if #(
  parameter int ADDR_W = 2
);

  logic              start;
  logic [31:0]       cfgData;
  logic              cfgValid;
  logic              cfgReady;
  logic [31:0]       seedValue;
  logic              loadSeed;
  logic              initState;
  logic              loadState;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;
  logic              zeroSeedSeen;

  modport master (
    output start, cfgData, cfgValid,
    input  cfgReady, seedValue, loadSeed, initState, loadState,
           address, busy, done, zeroSeedSeen
  );

  modport slave (
    input  start, cfgData, cfgValid,
    output cfgReady, seedValue, loadSeed, initState, loadState,
           address, busy, done, zeroSeedSeen
  );

endinterface

`default_nettype wire

// File: rtl/agent_config_loader.sv
// ============================================================================
//  Module      : agent_config_loader
//  Description : Streams seed/state word pairs into the agent array in
//                address order, emitting registered load pulses with the
//                matching address, then a one-cycle done pulse.
//  Config      : SEED_ZERO_GUARD_EN - substitute a zero seed with
//                SEED_ZERO_SUB and raise the sticky zeroSeedSeen flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module agent_config_loader
  import agent_cfg_pkg::*;
#(
  parameter int NUM_AGENTS = 4,
  parameter int ADDR_W     = 2
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  agent_config_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_AGENTS - 1);

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       seedValue_q, seedValue_d;
  logic              loadSeed_q, loadSeed_d;
  logic              initState_q, initState_d;
  logic              loadState_q, loadState_d;
  logic [ADDR_W-1:0] address_q, address_d;

  logic              w_ready;
  logic              w_accept;
  logic              w_zero_hit;
  logic [31:0]       w_seed;
  cfg_word_e         w_word;

  assign w_ready  = (state_q == ST_SEED) || (state_q == ST_STATE);
  assign w_accept = w_ready && bus.cfgValid;
  assign w_word   = (state_q == ST_SEED) ? WORD_A : WORD_B;

`ifdef SEED_ZERO_GUARD_EN
  assign w_seed     = guard_seed(bus.cfgData);
  assign w_zero_hit = w_accept && (w_word == WORD_A) && (bus.cfgData == 32'd0);
`else
  assign w_seed     = bus.cfgData;
  assign w_zero_hit = 1'b0;
`endif

  // Next-state, index and output-register computation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seedValue_d = seedValue_q;
    loadSeed_d  = 1'b0;
    initState_d = initState_q;
    loadState_d = 1'b0;
    address_d   = address_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          state_d = ST_SEED;
        end
      end

      ST_SEED, ST_STATE: begin
        if (w_accept) begin
          address_d = idx_q;
          if (w_word == WORD_A) begin
            seedValue_d = w_seed;
            loadSeed_d  = 1'b1;
            state_d     = ST_STATE;
          end else begin
            initState_d = bus.cfgData[STATE_BIT] ? AGENT_INF : AGENT_SUS;
            loadState_d = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = ST_SEED;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State, index and registered outputs; reset clears everything
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      seedValue_q <= '0;
      loadSeed_q  <= 1'b0;
      initState_q <= 1'b0;
      loadState_q <= 1'b0;
      address_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seedValue_q <= seedValue_d;
      loadSeed_q  <= loadSeed_d;
      initState_q <= initState_d;
      loadState_q <= loadState_d;
      address_q   <= address_d;
    end
  end

`ifdef SEED_ZERO_GUARD_EN
  logic zeroSeen_q;

  // Sticky record that a zero seed was replaced; only reset clears it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zeroSeen_q <= 1'b0;
    end else if (w_zero_hit) begin
      zeroSeen_q <= 1'b1;
    end
  end

  assign bus.zeroSeedSeen = zeroSeen_q;
`else
  assign bus.zeroSeedSeen = w_zero_hit;
`endif

  assign bus.cfgReady  = w_ready;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.seedValue = seedValue_q;
  assign bus.loadSeed  = loadSeed_q;
  assign bus.initState = initState_q;
  assign bus.loadState = loadState_q;
  assign bus.address   = address_q;

endmodule

`default_nettype wire

// File: tb/tb_agent_config_loader.sv
// ============================================================================
//  Module      : tb_agent_config_loader
//  Description : Self-checking bench for agent_config_loader (4 agents).
//                Table of directed vectors, hand-written corner sequences and
//                random traffic compared against a word-count based model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_agent_config_loader;

  localparam int NA = 4;
`ifdef SEED_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  agent_config_loader_if #(.ADDR_W(2)) bus ();

  agent_config_loader #(.NUM_AGENTS(NA), .ADDR_W(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: progress is tracked as number of words accepted
  bit          m_ready, m_busy, m_done;
  int          m_words;
  bit          e_ls, e_lst, e_init, e_zero;
  logic [1:0]  e_addr;
  logic [31:0] e_seed;

  typedef struct {
    logic        st;
    logic        v;
    logic [31:0] d;
    logic        rdy, bsy, dn, ls, lst, ini;
    logic [1:0]  addr;
    logic [31:0] seed;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic st, input logic v, input logic [31:0] d,
                              input logic rdy, input logic bsy, input logic dn,
                              input logic ls, input logic lst, input logic ini,
                              input logic [1:0] addr, input logic [31:0] seed);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.bsy = bsy; r.dn = dn;
    r.ls = ls; r.lst = lst; r.ini = ini; r.addr = addr; r.seed = seed;
    return r;
  endfunction

  function automatic logic [40:0] obs_now();
    return {bus.cfgReady, bus.busy, bus.done, bus.loadSeed, bus.loadState,
            bus.initState, bus.address, bus.zeroSeedSeen, bus.seedValue};
  endfunction

  function automatic logic [40:0] obs_model();
    return {m_ready, m_busy, m_done, e_ls, e_lst, e_init, e_addr, e_zero, e_seed};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_clear();
    m_ready = 0; m_busy = 0; m_done = 0; m_words = 0;
    e_ls = 0; e_lst = 0; e_init = 0; e_zero = 0; e_addr = 2'd0; e_seed = 32'd0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance model, compare
  task automatic cycle(input string name, input logic st, input logic v, input logic [31:0] d);
    bit acc;
    int w;
    bus.start = st; bus.cfgValid = v; bus.cfgData = d;
    acc = m_ready && v;
    w   = m_words;
    e_ls = 0; e_lst = 0;
    if (acc) begin
      if (w % 2 == 0) begin
        e_ls   = 1;
        e_seed = (GUARD && d == 32'd0) ? 32'h1 : d;
        if (GUARD && d == 32'd0) e_zero = 1;
      end else begin
        e_lst  = 1;
        e_init = d[0];
      end
      e_addr = 2'(w / 2);
    end
    if (!m_busy) begin
      if (st) begin m_busy = 1; m_ready = 1; m_words = 0; end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (acc) begin
      m_words = w + 1;
      if (m_words == 2 * NA) begin m_ready = 0; m_done = 1; end
    end
    @(posedge clk); #1;
    chk(name, 64'(obs_now()), 64'(obs_model()));
  endtask

  // Asynchronous reset asserted away from the clock edge
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("reset_async", 64'(obs_now()), 64'd0);
    model_clear();
    bus.start = 0; bus.cfgValid = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.cfgValid = 0; bus.cfgData = 32'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(obs_now()), 64'd0);
    rstn = 1'b1;

    // ---- Directed back-to-back load table ----
    tbl[0]  = mk(1, 0, 32'h0,        1, 1, 0, 0, 0, 0, 2'd0, 32'h00);
    tbl[1]  = mk(0, 1, 32'h11,       1, 1, 0, 1, 0, 0, 2'd0, 32'h11);
    tbl[2]  = mk(0, 1, 32'h1,        1, 1, 0, 0, 1, 1, 2'd0, 32'h11);
    tbl[3]  = mk(0, 1, 32'h22,       1, 1, 0, 1, 0, 1, 2'd1, 32'h22);
    tbl[4]  = mk(0, 1, 32'hFFFFFFFE, 1, 1, 0, 0, 1, 0, 2'd1, 32'h22);
    tbl[5]  = mk(0, 1, 32'h33,       1, 1, 0, 1, 0, 0, 2'd2, 32'h33);
    tbl[6]  = mk(0, 1, 32'h0,        1, 1, 0, 0, 1, 0, 2'd2, 32'h33);
    tbl[7]  = mk(0, 1, 32'h44,       1, 1, 0, 1, 0, 0, 2'd3, 32'h44);
    tbl[8]  = mk(0, 1, 32'h80000001, 0, 1, 1, 0, 1, 1, 2'd3, 32'h44);
    tbl[9]  = mk(0, 1, 32'h55,       0, 0, 0, 0, 0, 1, 2'd3, 32'h44);
    tbl[10] = mk(0, 0, 32'h66,       0, 0, 0, 0, 0, 1, 2'd3, 32'h44);
    for (int i = 0; i < 11; i++) begin
      cycle("tbl_model", tbl[i].st, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl_row%0d", i), 64'(obs_now()),
          64'({tbl[i].rdy, tbl[i].bsy, tbl[i].dn, tbl[i].ls, tbl[i].lst,
               tbl[i].ini, tbl[i].addr, 1'b0, tbl[i].seed}));
    end

    // ---- Backpressure: 3-cycle gaps between every word ----
    cycle("bp_start", 1, 0, 32'h0);
    for (int k = 0; k < 2 * NA; k++) begin
      cycle("bp_word", 0, 1, 32'hA000_0000 + 32'(k));
      for (int g = 0; g < 3; g++) cycle("bp_gap", 0, 0, $urandom());
    end
    chk("bp_idle_after", 64'(bus.busy), 64'd0);
    chk("bp_last_addr", 64'(bus.address), 64'd3);

    // ---- start while busy is ignored, including during DONE ----
    cycle("sb_start", 1, 0, 32'h0);
    cycle("sb_w0", 0, 1, 32'hBEEF0000);
    cycle("sb_w1", 0, 1, 32'h0);
    cycle("sb_restart", 1, 1, 32'hBEEF0001);
    chk("sb_addr_kept", 64'({bus.loadSeed, bus.address}), 64'({1'b1, 2'd1}));
    for (int k = 3; k < 2 * NA; k++) cycle("sb_word", 1, 1, 32'hBEEF0000 + 32'(k));
    chk("sb_done", 64'(bus.done), 64'd1);
    cycle("sb_in_done", 1, 0, 32'h0);
    chk("sb_not_restarted", 64'({bus.busy, bus.cfgReady}), 64'd0);
    cycle("sb_idle", 0, 0, 32'h0);

    // ---- Zero seed ----
    cycle("zs_start", 1, 0, 32'h0);
    cycle("zs_seed0", 0, 1, 32'h0);
    chk("zs_seed_value", 64'(bus.seedValue), GUARD ? 64'd1 : 64'd0);
    chk("zs_flag", 64'(bus.zeroSeedSeen), 64'(GUARD));
    for (int k = 1; k < 2 * NA; k++) cycle("zs_word", 0, 1, 32'h7 + 32'(k));
    chk("zs_flag_at_done", 64'({bus.done, bus.zeroSeedSeen}), 64'({1'b1, GUARD}));
    cycle("zs_idle", 0, 0, 32'h0);

    // ---- Reset mid-stream during agent 2's seed word ----
    cycle("rm_start", 1, 0, 32'h0);
    for (int k = 0; k < 4; k++) cycle("rm_word", 0, 1, 32'hC0 + 32'(k));
    bus.cfgValid = 1; bus.cfgData = 32'hC4;
    do_reset();
    cycle("rm_restart", 1, 0, 32'h0);
    cycle("rm_first", 0, 1, 32'hD0);
    chk("rm_addr0", 64'({bus.loadSeed, bus.address, bus.seedValue}),
        64'({1'b1, 2'd0, 32'hD0}));
    for (int k = 1; k < 2 * NA; k++) cycle("rm_word2", 0, 1, 32'hD0 + 32'(k));
    cycle("rm_idle", 0, 0, 32'h0);

    // ---- Random traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset();
      else
        cycle("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom()));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
